branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-side gshare direction predictor plus direct-mapped BTB, directly upstream of the execute stage.
- Each cycle it looks up the fetch PC and produces a predicted next PC plus the metadata that travels down the pipe: pred_taken, pht_idx, btb_hit, btb_target.
- The execute stage resolves the control instruction and returns it on the update port; this block then trains the PHT, GHR and BTB.
- Updates are non-speculative: the GHR is written only on resolved branches.

Parameters:
- PHT_BITS, 8, log2 of PHT entries; also the GHR width and the pht_idx width.
- BTB_BITS, 6, log2 of BTB entries.
- TAG_BITS, 32-2-BTB_BITS (=24), BTB tag width, taken from pc[31:2+BTB_BITS].

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- F_pc  in  32  current fetch PC.
- F_pred_taken  out  1  predicted direction.
- F_pht_idx  out  PHT_BITS  PHT index used for this lookup.
- F_btb_hit  out  1  valid BTB entry with matching tag.
- F_btb_target  out  32  BTB target; 0 when no hit.
- F_next_pc  out  32  predicted next fetch PC.
- ex_update_en  in  1  resolved control instruction this cycle (branch/JAL/JALR).
- ex_is_cond  in  1  1 = conditional branch, 0 = JAL/JALR.
- ex_pc  in  32  PC of the resolved instruction.
- ex_pht_idx  in  PHT_BITS  pht_idx carried down from fetch.
- ex_actual_taken  in  1  resolved direction.
- ex_actual_target  in  32  resolved target.

Behaviour:

Lookup (combinational from F_pc and current state):
- F_pht_idx = F_pc[PHT_BITS+1:2] ^ ghr.
- hit = btb_valid[i] & (btb_tag[i] == F_pc[31:2+BTB_BITS]), where i = F_pc[BTB_BITS+1:2].
- F_pred_taken = (hit & btb_jump[i]) | pht[F_pht_idx][1]. This may be 1 without a hit; execute handles that case.
- F_next_pc = (F_pred_taken & hit) ? btb_target[i] : F_pc + 4.

Update (rising clk, when ex_update_en):
- Conditional branch (ex_is_cond=1):
  - pht[ex_pht_idx] saturating increment if taken, decrement if not. Saturate at 2'b11 and 2'b00.
  - ghr <= {ghr[PHT_BITS-2:0], ex_actual_taken}.
- Any taken instruction: write BTB index ex_pc[BTB_BITS+1:2] with valid=1, tag=ex_pc[31:2+BTB_BITS], target=ex_actual_target, jump=~ex_is_cond. Overwrite unconditionally (no replacement policy).
- Not-taken: BTB unchanged; an existing entry is not invalidated.
- JAL/JALR: PHT and GHR unchanged.

Timing and conflicts:
- Update latency is 1 cycle: a lookup in the cycle after the update edge sees the new state.
- Read/write of the same entry in the same cycle: the lookup returns the pre-update value (no bypass). The GHR used for indexing is the registered value.
- ex_update_en=0: no state changes.

Reset (async, rst=0):
- All PHT counters = 2'b01 (weakly not-taken); all btb_valid = 0; ghr = 0.
- BTB tag, target and jump bits also clear to 0.
- Outputs immediately after reset: F_btb_hit=0, F_btb_target=0, F_pred_taken=0, F_next_pc=F_pc+4, F_pht_idx=F_pc[9:2].
- Reset asserted mid-operation discards all training; an update presented in the same cycle as reset is ignored.

Width and wrap rules:
- F_pc+4 wraps modulo 2^32.
- pc[1:0] is ignored for all indexing and tags.

Decomposition:
- Package bp_pkg holds:
  - PHT_BITS, BTB_BITS, TAG_BITS.
  - Counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - typedef btb_entry_t {valid, jump, tag, target}.
- One sub-module, bp_btb: BTB storage with async-reset valid bits, combinational read, single write port.
- PHT and GHR stay in branch_predictor.

Test Plan:
- Reset, F_pc=0x100 -> F_pred_taken=0, F_btb_hit=0, F_next_pc=0x104, F_pht_idx=0x40.
- Update cond branch ex_pc=0x100, ex_pht_idx=0x40, taken, target=0x80 -> next cycle, F_pc=0x100 gives hit=1, target=0x80. ghr=0x01, so F_pht_idx=0x41. Counter 0x41 is still 01, so pred_taken=0 and next_pc=0x104.
- Four not-taken updates on idx 0x10 from reset -> counter 00 (saturates). Then three taken -> 11. A fourth taken -> stays 11, and the lookup at that idx gives pred_taken=1.
- JAL update ex_pc=0x200, target=0x400, ex_is_cond=0 -> F_pc=0x200 gives pred_taken=1, next_pc=0x400. GHR unchanged, PHT unchanged.
- Alias: taken update ex_pc=0x1100 (same BTB index as 0x100, different tag) -> F_pc=0x100 gives hit=0. F_pc=0x1100 gives hit=1.
- Same-cycle update and lookup of the same BTB index -> old value seen this cycle, new value next cycle. rst pulsed low mid-run -> all hits drop immediately and the counters return to 01.

Source files
------------

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared sizes, counter encodings and BTB entry type for the branch predictor
package bp_pkg;

    localparam int PHT_BITS    = 8;
    localparam int BTB_BITS    = 6;
    localparam int TAG_BITS    = 32 - 2 - BTB_BITS;
    localparam int PHT_ENTRIES = 1 << PHT_BITS;
    localparam int BTB_ENTRIES = 1 << BTB_BITS;

    // Two-bit saturating direction counter states; bit 1 is the prediction.
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef struct packed {
        logic                valid;
        logic                jump;
        logic [TAG_BITS-1:0] tag;
        logic [31:0]         target;
    } btb_entry_t;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == ST) ? ST : ctr + 2'd1;
        end
        return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/bp_btb.sv
// rtl/bp_btb.sv - direct-mapped BTB storage, combinational read, single write port
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset (clears every entry)
//   rd_idx/rd_entry  combinational lookup; returns the stored (pre-write) entry
//   wr_en/wr_idx/wr_entry  registered overwrite of one entry
module bp_btb
    import bp_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [BTB_BITS-1:0] rd_idx,
    output btb_entry_t          rd_entry,
    input  logic                wr_en,
    input  logic [BTB_BITS-1:0] wr_idx,
    input  btb_entry_t          wr_entry
);

    btb_entry_t mem [BTB_ENTRIES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_entry;
        end
    end

    // No write bypass: a same-cycle write becomes visible after the edge.
    assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - gshare direction predictor plus direct-mapped BTB on the fetch path
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   F_pc                fetch PC looked up this cycle
//   F_pred_taken        predicted direction
//   F_pht_idx           PHT index used, carried down the pipe for training
//   F_btb_hit           valid BTB entry with matching tag
//   F_btb_target        BTB target on hit, else 0
//   F_next_pc           predicted next fetch PC
//   ex_*                resolved control instruction returned from execute
module branch_predictor
    import bp_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         F_pc,
    output logic                F_pred_taken,
    output logic [PHT_BITS-1:0] F_pht_idx,
    output logic                F_btb_hit,
    output logic [31:0]         F_btb_target,
    output logic [31:0]         F_next_pc,
    input  logic                ex_update_en,
    input  logic                ex_is_cond,
    input  logic [31:0]         ex_pc,
    input  logic [PHT_BITS-1:0] ex_pht_idx,
    input  logic                ex_actual_taken,
    input  logic [31:0]         ex_actual_target
);

    logic [1:0]          pht [PHT_ENTRIES];
    logic [PHT_BITS-1:0] ghr;

    btb_entry_t rd_entry;
    btb_entry_t wr_entry;
    logic       btb_wr_en;
    logic       hit;
    logic [1:0] pht_ctr;

    // Byte-offset bits never participate in indexing or tags.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{F_pc[1:0], ex_pc[1:0]};

    // Every taken control instruction (conditional or jump) trains the BTB;
    // not-taken resolutions leave any existing entry in place.
    assign btb_wr_en       = ex_update_en & ex_actual_taken;
    assign wr_entry.valid  = 1'b1;
    assign wr_entry.jump   = ~ex_is_cond;
    assign wr_entry.tag    = ex_pc[31:2+BTB_BITS];
    assign wr_entry.target = ex_actual_target;

    bp_btb u_btb (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (F_pc[BTB_BITS+1:2]),
        .rd_entry (rd_entry),
        .wr_en    (btb_wr_en),
        .wr_idx   (ex_pc[BTB_BITS+1:2]),
        .wr_entry (wr_entry)
    );

    assign F_pht_idx = F_pc[PHT_BITS+1:2] ^ ghr;
    assign pht_ctr   = pht[F_pht_idx];

    always_comb begin
        hit          = rd_entry.valid && (rd_entry.tag == F_pc[31:2+BTB_BITS]);
        F_btb_hit    = hit;
        F_btb_target = hit ? rd_entry.target : 32'd0;
        // A PHT-taken prediction without a BTB hit still falls through to
        // pc+4; execute detects and repairs that case.
        F_pred_taken = (hit & rd_entry.jump) | pht_ctr[1];
        F_next_pc    = (F_pred_taken & hit) ? rd_entry.target : F_pc + 32'd4;
    end

    // Training is non-speculative: only resolved conditional branches move
    // the counters and the global history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht[i] <= WNT;
            end
            ghr <= '0;
        end else if (ex_update_en && ex_is_cond) begin
            pht[ex_pht_idx] <= ctr_next(pht[ex_pht_idx], ex_actual_taken);
            ghr             <= {ghr[PHT_BITS-2:0], ex_actual_taken};
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] F_pc;
    logic        F_pred_taken;
    logic [7:0]  F_pht_idx;
    logic        F_btb_hit;
    logic [31:0] F_btb_target;
    logic [31:0] F_next_pc;
    logic        ex_update_en;
    logic        ex_is_cond;
    logic [31:0] ex_pc;
    logic [7:0]  ex_pht_idx;
    logic        ex_actual_taken;
    logic [31:0] ex_actual_target;

    branch_predictor dut (
        .clk              (clk),
        .rst              (rst),
        .F_pc             (F_pc),
        .F_pred_taken     (F_pred_taken),
        .F_pht_idx        (F_pht_idx),
        .F_btb_hit        (F_btb_hit),
        .F_btb_target     (F_btb_target),
        .F_next_pc        (F_next_pc),
        .ex_update_en     (ex_update_en),
        .ex_is_cond       (ex_is_cond),
        .ex_pc            (ex_pc),
        .ex_pht_idx       (ex_pht_idx),
        .ex_actual_taken  (ex_actual_taken),
        .ex_actual_target (ex_actual_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        taken;
        logic [7:0]  idx;
        logic        hit;
        logic [31:0] tgt;
        logic [31:0] nxt;
    } exp_t;

    typedef struct {
        logic        upd;
        logic        cond;
        logic        tk;
        logic [31:0] ex_pc;
        logic [7:0]  ex_idx;
        logic [31:0] ex_tgt;
        logic [31:0] f_pc;
        logic        e_taken;
        logic [7:0]  e_idx;
        logic        e_hit;
        logic [31:0] e_tgt;
        logic [31:0] e_nxt;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model of predictor state
    logic [1:0]  m_pht   [256];
    logic [7:0]  m_ghr;
    logic        m_valid [64];
    logic        m_jump  [64];
    logic [23:0] m_tag   [64];
    logic [31:0] m_tgt   [64];

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_pht[i] = 2'b01;
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_jump[i]  = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
        end
        m_ghr = '0;
    endtask

    task automatic model_update();
        int bi;
        if (ex_update_en) begin
            if (ex_is_cond) begin
                if (ex_actual_taken) begin
                    if (m_pht[ex_pht_idx] != 2'b11) m_pht[ex_pht_idx] = m_pht[ex_pht_idx] + 2'b01;
                end else begin
                    if (m_pht[ex_pht_idx] != 2'b00) m_pht[ex_pht_idx] = m_pht[ex_pht_idx] - 2'b01;
                end
                m_ghr = {m_ghr[6:0], ex_actual_taken};
            end
            if (ex_actual_taken) begin
                bi          = int'(ex_pc[7:2]);
                m_valid[bi] = 1'b1;
                m_jump[bi]  = ~ex_is_cond;
                m_tag[bi]   = ex_pc[31:8];
                m_tgt[bi]   = ex_actual_target;
            end
        end
    endtask

    function automatic exp_t model_expect(input logic [31:0] pc);
        exp_t e;
        int   bi;
        logic [1:0] c;
        bi      = int'(pc[7:2]);
        e.idx   = pc[9:2] ^ m_ghr;
        e.hit   = m_valid[bi] && (m_tag[bi] == pc[31:8]);
        e.tgt   = e.hit ? m_tgt[bi] : 32'd0;
        c       = m_pht[e.idx];
        e.taken = (e.hit && m_jump[bi]) || c[1];
        e.nxt   = (e.taken && e.hit) ? m_tgt[bi] : pc + 32'd4;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got nothing, expected an entry", name);
        end else begin
            n_checks--;
            e = sb.pop_front();
            chk({name, ".taken"}, {31'd0, F_pred_taken}, {31'd0, e.taken});
            chk({name, ".idx"},   {24'd0, F_pht_idx},    {24'd0, e.idx});
            chk({name, ".hit"},   {31'd0, F_btb_hit},    {31'd0, e.hit});
            chk({name, ".tgt"},   F_btb_target,          e.tgt);
            chk({name, ".next"},  F_next_pc,             e.nxt);
        end
    endtask

    task automatic set_upd(input logic en, input logic cond, input logic [31:0] pc,
                           input logic [7:0] idx, input logic tk, input logic [31:0] tgt);
        ex_update_en     = en;
        ex_is_cond       = cond;
        ex_pc            = pc;
        ex_pht_idx       = idx;
        ex_actual_taken  = tk;
        ex_actual_target = tgt;
    endtask

    // Drive a lookup and check it against the model; settles #1 later.
    task automatic lookup_model(input logic [31:0] pc, input string name);
        F_pc = pc;
        sb.push_back(model_expect(pc));
        #1;
        pop_check(name);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_update();
        #1;
    endtask

    vec_t vecs[14];
    logic exp_sat[9];

    initial begin
        // junk ex_* payload on idle rows must be ignored while ex_update_en=0
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 32'h200,  8'h41, 32'hBAD0, 32'h100,      1'b0, 8'h40, 1'b0, 32'h0,    32'h104};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h200,  8'h41, 32'hBAD0, 32'hFFFFFFFC, 1'b0, 8'hFF, 1'b0, 32'h0,    32'h0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'h100,  8'h40, 32'h80,   32'h100,      1'b0, 8'h40, 1'b0, 32'h0,    32'h104};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h200,  8'h41, 32'hBAD0, 32'h100,      1'b0, 8'h41, 1'b1, 32'h80,   32'h104};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h200,  8'h41, 32'hBAD0, 32'h103,      1'b0, 8'h41, 1'b1, 32'h80,   32'h107};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h200,  8'h81, 32'h400,  32'h200,      1'b0, 8'h81, 1'b0, 32'h0,    32'h204};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h200,  8'h41, 32'hBAD0, 32'h200,      1'b1, 8'h81, 1'b1, 32'h400,  32'h400};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h200,  8'h41, 32'hBAD0, 32'h600,      1'b0, 8'h81, 1'b0, 32'h0,    32'h604};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 32'h1100, 8'h44, 32'h3000, 32'h100,      1'b0, 8'h41, 1'b0, 32'h0,    32'h104};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h200,  8'h41, 32'hBAD0, 32'h1100,     1'b0, 8'h43, 1'b1, 32'h3000, 32'h1104};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 32'h200,  8'h41, 32'hBAD0, 32'h100,      1'b0, 8'h43, 1'b0, 32'h0,    32'h104};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 32'h200,  8'h41, 32'hBAD0, 32'h11C,      1'b1, 8'h44, 1'b0, 32'h0,    32'h120};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 32'h1100, 8'h43, 32'hBAD0, 32'h1100,     1'b0, 8'h43, 1'b1, 32'h3000, 32'h1104};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 32'h200,  8'h41, 32'hBAD0, 32'h1100,     1'b0, 8'h46, 1'b1, 32'h3000, 32'h1104};

        // prediction bit at idx 0x10 before each of 8 updates (4 NT, 4 T) and after
        exp_sat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        // ---------------- reset ----------------
        rst = 1'b0;
        F_pc = 32'h100;
        set_upd(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // ---------------- directed table ----------------
        for (int r = 0; r < 14; r++) begin
            exp_t e;
            set_upd(vecs[r].upd, vecs[r].cond, vecs[r].ex_pc, vecs[r].ex_idx,
                    vecs[r].tk, vecs[r].ex_tgt);
            F_pc    = vecs[r].f_pc;
            e.taken = vecs[r].e_taken;
            e.idx   = vecs[r].e_idx;
            e.hit   = vecs[r].e_hit;
            e.tgt   = vecs[r].e_tgt;
            e.nxt   = vecs[r].e_nxt;
            sb.push_back(e);
            #2;
            pop_check($sformatf("vec%0d", r));
            tick();
        end

        // ---------------- counter saturation on idx 0x10 ----------------
        rst = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        for (int k = 0; k < 9; k++) begin
            logic [31:0] pc;
            if (k < 8) set_upd(1'b1, 1'b1, 32'h800000FC, 8'h10, (k >= 4), 32'h1234);
            else       set_upd(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 32'h0);
            pc = {22'd0, 8'h10 ^ m_ghr, 2'b00};
            lookup_model(pc, $sformatf("sat%0d", k));
            chk($sformatf("sat_const%0d", k), {31'd0, F_pred_taken}, {31'd0, exp_sat[k]});
            tick();
        end

        // ---------------- random training against the model ----------------
        for (int n = 0; n < 300; n++) begin
            logic [31:0] upc;
            logic [31:0] lpc;
            upc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            lpc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            set_upd(($urandom_range(0, 9) < 6), $urandom_range(0, 1), upc,
                    8'($urandom_range(0, 255)), $urandom_range(0, 1), $urandom);
            lookup_model(lpc, "rand");
            tick();
        end

        // ---------------- reset mid-run with a concurrent update ----------------
        set_upd(1'b1, 1'b0, 32'h3A0, 8'h00, 1'b1, 32'h5555);
        rst = 1'b0;
        model_reset();
        #1;
        for (int b = 0; b < 4; b++) begin
            F_pc = 32'h100 * b + 32'h4 * b;
            #1;
            chk("rst_hit", {31'd0, F_btb_hit}, 32'd0);
            chk("rst_taken", {31'd0, F_pred_taken}, 32'd0);
        end
        tick();
        rst = 1'b1;
        set_upd(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 32'h0);
        lookup_model(32'h3A0, "post_rst_upd");
        chk("post_rst_hit_const", {31'd0, F_btb_hit}, 32'd0);
        for (int b = 0; b < 8; b++) begin
            lookup_model(32'h104 + 32'h4 * b, "post_rst");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
